// File: rtl/miyajiro_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port between
// instruction fetch and load/store, with one fixed-latency transaction in flight.
module miyajiro_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [2:0] r_cnt;
    logic       r_owner;
    logic       r_rr;
    logic       r_isStore;

    logic w_grantData;
    logic w_grantIf;
    logic w_accept;
    logic w_respCycle;

    // owner/rr encoding: 0 = fetch, 1 = data; rr remembers the last winner
    assign w_grantData = d_req_valid && (!if_req_valid || !r_rr);
    assign w_grantIf   = if_req_valid && !w_grantData;
    assign w_accept    = !reset && (r_state == S_IDLE) && (if_req_valid || d_req_valid);
    assign w_respCycle = !reset && (r_state == S_BUSY) && (r_cnt == 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_owner   <= 1'b0;
            r_rr      <= 1'b1;
            r_isStore <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_cnt     <= LAT;
                r_owner   <= w_grantData;
                r_rr      <= w_grantData;
                r_isStore <= w_grantData && d_req_we;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nextState = S_BUSY;
            S_BUSY:  if (r_cnt == 3'd1) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        if_resp_valid = 1'b0;
        if_resp_data  = '0;
        d_resp_valid  = 1'b0;
        d_resp_data   = '0;
        mem_en        = 1'b0;
        mem_we        = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (w_accept) begin
            if_req_ready = w_grantIf;
            d_req_ready  = w_grantData;
            mem_en       = 1'b1;
            if (w_grantData) begin
                mem_addr  = d_req_addr;
                mem_wdata = d_req_wdata;
                if (d_req_we) mem_we = d_req_wstrb;
            end else begin
                mem_addr = if_req_addr;
            end
        end
        // Response is returned in the last wait cycle, straight from the memory port
        if (w_respCycle) begin
            if (r_owner) begin
                d_resp_valid = 1'b1;
                if (!r_isStore) d_resp_data = mem_rdata;
            end else begin
                if_resp_valid = 1'b1;
                if_resp_data  = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_miyajiro_mem_arbiter.sv
// Directed bench for miyajiro_mem_arbiter: four instances with MEM_LATENCY 1..4
// share the stimulus; each scenario checks the instance whose latency it targets.
module tb_miyajiro_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        ifValid;
    logic [31:0] ifAddr;
    logic        dValid;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dWstrb;
    logic [31:0] memRdata;
    logic [31:0] cycle;

    logic        ifReady   [4];
    logic        ifResp    [4];
    logic [31:0] ifData    [4];
    logic        dReady    [4];
    logic        dResp     [4];
    logic [31:0] dData     [4];
    logic        memEn     [4];
    logic [3:0]  memWe     [4];
    logic [31:0] memAddr   [4];
    logic [31:0] memWdata  [4];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 4; g++) begin : gDut
        miyajiro_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(g + 1)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .if_req_valid  (ifValid),
            .if_req_ready  (ifReady[g]),
            .if_req_addr   (ifAddr),
            .if_resp_valid (ifResp[g]),
            .if_resp_data  (ifData[g]),
            .d_req_valid   (dValid),
            .d_req_ready   (dReady[g]),
            .d_req_we      (dWe),
            .d_req_addr    (dAddr),
            .d_req_wdata   (dWdata),
            .d_req_wstrb   (dWstrb),
            .d_resp_valid  (dResp[g]),
            .d_resp_data   (dData[g]),
            .mem_en        (memEn[g]),
            .mem_we        (memWe[g]),
            .mem_addr      (memAddr[g]),
            .mem_wdata     (memWdata[g]),
            .mem_rdata     (memRdata)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory data changes every cycle so a response taken in the wrong cycle shows up
    initial cycle = 32'd0;
    always @(posedge clk) cycle <= cycle + 32'd1;
    assign memRdata = {16'hA5A5, cycle[15:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAll();
        reset   = 1'b1;
        ifValid = 1'b0;
        dValid  = 1'b0;
        dWe     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        ifValid = 1'b1;
        dValid  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({ifReady[i], dReady[i], memEn[i], ifResp[i], dResp[i]} !== 5'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_outputs inst%0d cyc%0d: got %b expected 00000", i, c,
                             {ifReady[i], dReady[i], memEn[i], ifResp[i], dResp[i]});
                end
            end
        end
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ifReady[i], dReady[i]} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL first_tie inst%0d: got %b expected 10", i, {ifReady[i], dReady[i]});
            end
        end
        ifValid = 1'b0;
        dValid  = 1'b0;
    endtask

    task automatic test_fetch_read();
        logic [31:0] expData;
        resetAll();
        ifValid = 1'b1;
        ifAddr  = 32'h100;
        #1;
        checks++;
        if ({memEn[0], ifReady[0], memAddr[0], memWe[0]} !== {1'b1, 1'b1, 32'h100, 4'h0}) begin
            errors++;
            $display("[TB] FAIL fetch_accept: got en=%b rdy=%b addr=%h we=%h expected 1 1 00000100 0",
                     memEn[0], ifReady[0], memAddr[0], memWe[0]);
        end
        tick();
        ifAddr = 32'h104;
        #1;
        expData = {16'hA5A5, cycle[15:0]};
        checks++;
        if ({ifResp[0], ifData[0], dResp[0]} !== {1'b1, expData, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fetch_resp: got v=%b data=%h dv=%b expected 1 %h 0",
                     ifResp[0], ifData[0], dResp[0], expData);
        end
        checks++;
        if ({ifReady[0], dReady[0], memEn[0]} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL fetch_busy_ready: got %b expected 000", {ifReady[0], dReady[0], memEn[0]});
        end
        tick();
        #1;
        checks++;
        if ({memEn[0], ifReady[0], memAddr[0]} !== {1'b1, 1'b1, 32'h104}) begin
            errors++;
            $display("[TB] FAIL fetch_next_accept: got en=%b rdy=%b addr=%h expected 1 1 00000104",
                     memEn[0], ifReady[0], memAddr[0]);
        end
        ifValid = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] expData;
        resetAll();
        dValid = 1'b1;
        dWe    = 1'b1;
        dAddr  = 32'h40;
        dWdata = 32'h12345678;
        dWstrb = 4'b0011;
        #1;
        checks++;
        if ({memEn[1], dReady[1], memWe[1], memAddr[1], memWdata[1]} !==
            {1'b1, 1'b1, 4'b0011, 32'h40, 32'h12345678}) begin
            errors++;
            $display("[TB] FAIL store_accept: got en=%b rdy=%b we=%b addr=%h wd=%h expected 1 1 0011 00000040 12345678",
                     memEn[1], dReady[1], memWe[1], memAddr[1], memWdata[1]);
        end
        tick();
        dValid = 1'b0;
        dWe    = 1'b0;
        #1;
        checks++;
        if ({dResp[1], memEn[1], memWe[1], memAddr[1]} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL store_wait: got dv=%b en=%b we=%b addr=%h expected all zero",
                     dResp[1], memEn[1], memWe[1], memAddr[1]);
        end
        tick();
        #1;
        checks++;
        if ({dResp[1], dData[1], ifResp[1]} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL store_resp: got dv=%b data=%h iv=%b expected 1 00000000 0",
                     dResp[1], dData[1], ifResp[1]);
        end
        tick();
        dValid = 1'b1;
        dAddr  = 32'h44;
        #1;
        checks++;
        if ({memEn[1], memWe[1], memAddr[1]} !== {1'b1, 4'b0000, 32'h44}) begin
            errors++;
            $display("[TB] FAIL load_accept: got en=%b we=%b addr=%h expected 1 0000 00000044",
                     memEn[1], memWe[1], memAddr[1]);
        end
        tick();
        dValid = 1'b0;
        tick();
        #1;
        expData = {16'hA5A5, cycle[15:0]};
        checks++;
        if ({dResp[1], dData[1]} !== {1'b1, expData}) begin
            errors++;
            $display("[TB] FAIL load_resp: got dv=%b data=%h expected 1 %h", dResp[1], dData[1], expData);
        end
    endtask

    task automatic test_contention();
        logic [3:0] expVec;
        int accepts;
        int owner;
        accepts = 0;
        resetAll();
        ifValid = 1'b1;
        dValid  = 1'b1;
        dWe     = 1'b0;
        ifAddr  = 32'h200;
        dAddr   = 32'h300;
        for (int k = 0; k < 12; k++) begin
            #1;
            owner = (k / 2) % 2;
            if (k % 2 == 0) expVec = {owner == 0, owner == 1, 1'b0, 1'b0};
            else            expVec = {1'b0, 1'b0, owner == 0, owner == 1};
            checks++;
            if ({ifReady[0], dReady[0], ifResp[0], dResp[0]} !== expVec) begin
                errors++;
                $display("[TB] FAIL contention cyc%0d: got %b expected %b", k,
                         {ifReady[0], dReady[0], ifResp[0], dResp[0]}, expVec);
            end
            if (k % 2 == 0) begin
                checks++;
                if (memAddr[0] !== ((owner == 1) ? 32'h300 : 32'h200)) begin
                    errors++;
                    $display("[TB] FAIL contention_addr cyc%0d: got %h expected %h", k, memAddr[0],
                             (owner == 1) ? 32'h300 : 32'h200);
                end
            end
            if (memEn[0] === 1'b1) accepts++;
            tick();
        end
        ifValid = 1'b0;
        dValid  = 1'b0;
        checks++;
        if (accepts !== 6) begin
            errors++;
            $display("[TB] FAIL contention_accepts: got %0d expected 6", accepts);
        end
    endtask

    task automatic test_stream();
        logic [2:0] expVec;
        logic [31:0] expData;
        resetAll();
        ifValid = 1'b1;
        ifAddr  = 32'h1000;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k % 4 == 0)      expVec = 3'b110;
            else if (k % 4 == 3) expVec = 3'b001;
            else                 expVec = 3'b000;
            checks++;
            if ({ifReady[2], memEn[2], ifResp[2]} !== expVec) begin
                errors++;
                $display("[TB] FAIL stream cyc%0d: got %b expected %b", k,
                         {ifReady[2], memEn[2], ifResp[2]}, expVec);
            end
            if (k % 4 == 3) begin
                expData = {16'hA5A5, cycle[15:0]};
                checks++;
                if (ifData[2] !== expData) begin
                    errors++;
                    $display("[TB] FAIL stream_data cyc%0d: got %h expected %h", k, ifData[2], expData);
                end
            end
            tick();
        end
        ifValid = 1'b0;
    endtask

    task automatic test_rr_after_single();
        resetAll();
        ifValid = 1'b1;
        ifAddr  = 32'h20;
        tick();
        ifValid = 1'b0;
        tick();
        ifValid = 1'b1;
        dValid  = 1'b1;
        #1;
        checks++;
        if ({ifReady[0], dReady[0]} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rr_after_fetch: got %b expected 01", {ifReady[0], dReady[0]});
        end
        ifValid = 1'b0;
        dValid  = 1'b0;
    endtask

    task automatic test_reset_busy();
        resetAll();
        dValid = 1'b1;
        dWe    = 1'b0;
        dAddr  = 32'h80;
        #1;
        checks++;
        if ({memEn[3], dReady[3]} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rbusy_accept: got %b expected 11", {memEn[3], dReady[3]});
        end
        tick();
        dValid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({dResp[3], memEn[3], ifReady[3], dReady[3]} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rbusy_in_reset: got %b expected 0000", {dResp[3], memEn[3], ifReady[3], dReady[3]});
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (dResp[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rbusy_t3_resp: got %b expected 0", dResp[3]);
        end
        tick();
        ifValid = 1'b1;
        dValid  = 1'b1;
        #1;
        checks++;
        if ({dResp[3], ifReady[3], dReady[3]} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL rbusy_t4: got resp/ifrdy/drdy=%b expected 010", {dResp[3], ifReady[3], dReady[3]});
        end
        ifValid = 1'b0;
        dValid  = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        ifValid = 1'b0;
        dValid  = 1'b0;
        dWe     = 1'b0;
        ifAddr  = 32'h0;
        dAddr   = 32'h0;
        dWdata  = 32'h0;
        dWstrb  = 4'h0;
        test_reset();
        test_fetch_read();
        test_store_load();
        test_contention();
        test_stream();
        test_rr_after_single();
        test_reset_busy();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miyajiro_mem_arbiter.md
# miyajiro_mem_arbiter

Single-port memory arbiter inside MIYAJIRO_CPU. It shares one synchronous-read memory port between the instruction-fetch requester and the load/store requester. Arbitration is round-robin, with at most one transaction outstanding. It sequences each access through a fixed-latency wait and returns the response to the requester that issued it.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..4
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle when valid&&ready
- if_req_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  one-cycle pulse: fetch data valid
- if_resp_data  out  DATA_W  fetch data
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store accepted when valid&&ready
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_W  load/store address
- d_req_wdata  in  DATA_W  store data
- d_req_wstrb  in  DATA_W/8  store byte enables
- d_resp_valid  out  1  one-cycle pulse: load data valid or store done
- d_resp_data  out  DATA_W  load data; 0 for stores
- mem_en  out  1  memory access strobe
- mem_we  out  DATA_W/8  byte write enables; 0 for reads
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en

## Operation
- States:
  - IDLE: can accept a request.
  - BUSY: a transaction is outstanding; cnt counts down from MEM_LATENCY; an owner bit records fetch or data.
- Grant in IDLE, combinational from the valids:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last (rr bit) is granted.
  - Exactly one ready is high, and only for the granted requester. Both readies are 0 in BUSY.
- Accept cycle (valid&&ready in IDLE):
  - mem_en=1. mem_addr and mem_wdata come from the granted requester.
  - mem_we = d_req_wstrb for a data store, otherwise 0.
  - Next state is BUSY with cnt=MEM_LATENCY. owner and rr are set to the granted requester.
- BUSY:
  - cnt decrements each cycle.
  - In the cycle where cnt==1 (MEM_LATENCY cycles after the accept), the owner's resp_valid pulses for one cycle and resp_data = mem_rdata (d_resp_data=0 for a store). Next state is IDLE.
- Outside the accept cycle: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- Requester contract: valid and its payload are held until accepted. The arbiter does not check this.
- Responses have no backpressure; requesters always consume them.
- A requester whose valid drops before it is granted loses nothing: the rr bit changes only on accept.

## Timing
- Reset values:
  - state=IDLE, cnt=0, owner=fetch.
  - rr=data, so fetch wins the first tie.
  - All ready, resp_valid, resp_data and mem_* outputs are 0 in the reset cycle. readies become combinational again from the next cycle.
- Latency: request accepted in cycle T; response pulse in cycle T+MEM_LATENCY.
- Throughput: at most one accept per MEM_LATENCY+1 cycles. Earliest next accept is cycle T+MEM_LATENCY+1.
- Simultaneous valids on consecutive transactions alternate strictly: fetch, data, fetch, ...
- Reset asserted in BUSY: the outstanding transaction is abandoned and no response is issued. State returns to the reset values on the next posedge.
- Reset together with valid in IDLE: no accept, mem_en=0.
- Counter: 3 bits, never wraps. cnt==0 only in IDLE.

## Test plan
- Reset: hold reset 2 cycles with both valids high -> both readies=0, mem_en=0, no resp pulses. Release -> if_req_ready=1, d_req_ready=0 in the first IDLE cycle.
- Fetch read, MEM_LATENCY=1: if addr 0x100 accepted at T, memory returns 0xDEADBEEF -> mem_en=1/addr 0x100 at T, if_resp_valid=1 with data 0xDEADBEEF at T+1, no readies at T+1, next accept at T+2.
- Store, MEM_LATENCY=2: d_req_we=1, addr 0x40, wdata 0x12345678, wstrb 0b0011 -> mem_we=0b0011 at T, d_resp_valid=1 with data 0 at T+2, if_resp_valid stays 0.
- Contention: both valids held high for 12 cycles, MEM_LATENCY=1 -> grants fetch, data, fetch, data; 6 accepts total; each response on the owner's port only.
- Single requester streaming: only fetch valid for 4 requests, MEM_LATENCY=3 -> accepts at T, T+4, T+8, T+12, responses at T+3, T+7, T+11, T+15.
- Reset mid-BUSY: load accepted at T, MEM_LATENCY=4, reset at T+2 -> no d_resp_valid at T+4. Fetch wins the first tie after release.
